// File: rtl/light_show_sequencer_pkg.sv
// Shared encodings for the light show sequencer: mode codes, FSM states and colour range.
// Used by the top and by the testbench.
package light_show_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_CYCLE  = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_SWEEP  = 2'b11;

    localparam logic [2:0] COLOUR_MIN = 3'd1;
    localparam logic [2:0] COLOUR_MAX = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_CYCLE,
        ST_BLINK,
        ST_SWEEP
    } state_e;

    function automatic state_e mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_MANUAL: return ST_MANUAL;
            MODE_CYCLE:  return ST_CYCLE;
            MODE_BLINK:  return ST_BLINK;
            default:     return ST_SWEEP;
        endcase
    endfunction

    // Same 1..6 wrap the selector's colour counter applies on a button edge.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == COLOUR_MAX) ? COLOUR_MIN : c + 3'd1;
    endfunction

endpackage

// File: rtl/light_show_sequencer_if.sv
// Control/status bundle between the user controls and the light show sequencer.
// Optional macro LIGHT_SHOW_HOLD_EN adds the hold input.
interface light_show_sequencer_if #(
    parameter int DWELL_W = 8
) ();

    logic               start;
    logic [1:0]         mode_sel;
    logic               stop;
    logic [DWELL_W-1:0] dwell;
    logic               man_button;
    logic               man_sel;
`ifdef LIGHT_SHOW_HOLD_EN
    logic               hold;
`endif
    logic               button;
    logic               sel;
    logic               busy;
    logic               done;
    logic [2:0]         colour_shadow;

    modport master (
        output start, mode_sel, stop, dwell, man_button, man_sel,
`ifdef LIGHT_SHOW_HOLD_EN
        output hold,
`endif
        input  button, sel, busy, done, colour_shadow
    );

    modport slave (
        input  start, mode_sel, stop, dwell, man_button, man_sel,
`ifdef LIGHT_SHOW_HOLD_EN
        input  hold,
`endif
        output button, sel, busy, done, colour_shadow
    );

endinterface

// File: rtl/light_show_sequencer_dwell_timer.sv
// Reloading down-counter that paces the timed modes; tick marks a step boundary.
// A load in the same cycle is seen immediately so a dwell of 1 ticks on the start cycle.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cur;

    always_comb begin
        cur   = load ? load_val : cnt_q;
        tick  = run && (cur == '0);
        cnt_d = cur;
        if (run) begin
            cnt_d = tick ? load_val : cur - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/light_show_sequencer.sv
// Mode controller driving button/sel of the lights selector, with a shadow of its colour counter.
// Optional macro LIGHT_SHOW_HOLD_EN enables the hold input that freezes the timed modes.
module light_show_sequencer
    import light_show_pkg::*;
#(
    parameter int DWELL_W     = 8,
    parameter int SWEEP_STEPS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    light_show_sequencer_if.slave bus
);

    localparam int STEP_W = $clog2(SWEEP_STEPS + 1);

    state_e             state_q, state_d, state_eff;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_eff, load_val;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               button_q, button_d;
    logic               sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         colour_q, colour_d;
    logic               accept, timed, sweep_end, hold, run, tick;

`ifdef LIGHT_SHOW_HOLD_EN
    assign hold = bus.hold;
`else
    assign hold = 1'b0;
`endif

    // The timer also runs in the accepting cycle so the first step lands dwell cycles after start.
    always_comb begin
        accept    = (state_q == ST_IDLE) && bus.start && !bus.stop;
        dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        load_val  = accept ? dwell_eff - DWELL_W'(1) : dwell_q - DWELL_W'(1);
        timed     = (state_q == ST_CYCLE) || (state_q == ST_BLINK) || (state_q == ST_SWEEP);
        sweep_end = (state_q == ST_SWEEP) && (step_q == STEP_W'(SWEEP_STEPS));
        run       = (accept && (bus.mode_sel != MODE_MANUAL))
                  || (timed && !hold && !bus.stop && !sweep_end);
    end

    dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (load_val),
        .run      (run),
        .tick     (tick)
    );

    always_comb begin
        state_eff = accept ? mode_to_state(bus.mode_sel) : state_q;
        state_d   = state_eff;
        dwell_d   = accept ? dwell_eff : dwell_q;
        step_d    = accept ? '0 : step_q;
        button_d  = 1'b0;
        sel_d     = sel_q;
        done_d    = 1'b0;
        case (state_eff)
            ST_IDLE: begin
                sel_d = 1'b1;
            end
            ST_MANUAL: begin
                if (!accept) begin
                    button_d = bus.man_button;
                    sel_d    = bus.man_sel;
                end
            end
            ST_CYCLE: begin
                sel_d    = 1'b1;
                button_d = tick;
            end
            ST_BLINK: begin
                if (tick) begin
                    sel_d = !sel_q;
                end
            end
            ST_SWEEP: begin
                button_d = tick;
                if (tick) begin
                    step_d = step_d + STEP_W'(1);
                end
                if (sweep_end && !hold) begin
                    state_d = ST_IDLE;
                    sel_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Stop wins over a pulse, a sweep completion or anything else due this cycle.
        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            button_d = 1'b0;
            sel_d    = 1'b1;
            done_d   = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Mirrors the selector: it leaves 0 on the first clock out of reset, then steps on button.
    always_comb begin
        colour_d = colour_q;
        if (colour_q == 3'd0) begin
            colour_d = COLOUR_MIN;
        end else if (button_q) begin
            colour_d = next_colour(colour_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            step_q   <= '0;
            button_q <= 1'b0;
            sel_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            step_q   <= step_d;
            button_q <= button_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            colour_q <= colour_d;
        end
    end

    assign bus.button        = button_q;
    assign bus.sel           = sel_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.colour_shadow = colour_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
// Self-checking bench for light_show_sequencer: cycle-indexed mode model plus directed literal checks.
// Builds with or without LIGHT_SHOW_HOLD_EN (hold is tied low).
module tb_light_show_sequencer;
    import light_show_pkg::*;

    localparam int DW    = 8;
    localparam int STEPS = 6;

    localparam int M_IDLE   = 0;
    localparam int M_MANUAL = 1;
    localparam int M_CYCLE  = 2;
    localparam int M_BLINK  = 3;
    localparam int M_SWEEP  = 4;

    // k is the number of cycles since the accepted start; d is the effective dwell.
    typedef struct packed {
        logic       valid;
        int         st;
        int         k;
        int         d;
        logic       button;
        logic       sel;
        logic       busy;
        logic       done;
        logic [2:0] shadow;
    } model_t;

    logic   clk;
    logic   rst;
    int     cyc;
    int     checks;
    int     errors;
    int     t0;
    model_t m;
    int     blinkSel[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

    light_show_sequencer_if #(.DWELL_W(DW)) bus ();

    light_show_sequencer #(
        .DWELL_W     (DW),
        .SWEEP_STEPS (STEPS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic model_t modelStep(input model_t cur, input logic r, input logic s,
                                         input logic stp, input logic [1:0] mode,
                                         input logic [DW-1:0] dw, input logic mb, input logic ms);
        model_t n;
        n       = cur;
        n.valid = 1'b1;
        n.done  = 1'b0;
        if (r) begin
            n.st     = M_IDLE;
            n.k      = 0;
            n.d      = 1;
            n.button = 1'b0;
            n.sel    = 1'b1;
            n.busy   = 1'b0;
            n.shadow = 3'd0;
            return n;
        end
        if (cur.shadow == 3'd0)
            n.shadow = 3'd1;
        else if (cur.button)
            n.shadow = 3'((int'(cur.shadow) % 6) + 1);
        if (cur.st != M_IDLE && stp) begin
            n.st = M_IDLE;
        end else if (cur.st == M_IDLE && s && !stp) begin
            n.st = int'(mode) + 1;
            n.d  = (dw == '0) ? 1 : int'(dw);
            n.k  = 0;
        end else if (cur.st == M_SWEEP && cur.k == STEPS * cur.d) begin
            n.st   = M_IDLE;
            n.done = 1'b1;
        end
        if (n.st != M_IDLE) n.k = n.k + 1;
        n.busy   = (n.st != M_IDLE);
        n.button = 1'b0;
        n.sel    = 1'b1;
        case (n.st)
            M_MANUAL: if (n.k > 1) begin
                n.button = mb;
                n.sel    = ms;
            end
            M_CYCLE, M_SWEEP: n.button = ((n.k % n.d) == 0);
            M_BLINK:          n.sel    = (((n.k / n.d) % 2) == 0);
            default:          ;
        endcase
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] md, input logic [DW-1:0] dw,
                                 input logic stp, input logic mb, input logic ms);
        bus.start      = s;
        bus.mode_sel   = md;
        bus.dwell      = dw;
        bus.stop       = stp;
        bus.man_button = mb;
        bus.man_sel    = ms;
    endtask

    task automatic waitTo(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        m = '0;
        forever begin
            @(posedge clk);
            m = modelStep(m, rst, bus.start, bus.stop, bus.mode_sel, bus.dwell,
                          bus.man_button, bus.man_sel);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m.valid) begin
                checkOutput("model_button", 32'(bus.button), 32'(m.button));
                checkOutput("model_sel", 32'(bus.sel), 32'(m.sel));
                checkOutput("model_busy", 32'(bus.busy), 32'(m.busy));
                checkOutput("model_done", 32'(bus.done), 32'(m.done));
                checkOutput("model_shadow", 32'(bus.colour_shadow), 32'(m.shadow));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
`ifdef LIGHT_SHOW_HOLD_EN
        bus.hold = 1'b0;
`endif
        applyStimulus(1'b0, MODE_MANUAL, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_button", 32'(bus.button), 0);
        checkOutput("rst_sel", 32'(bus.sel), 1);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_shadow", 32'(bus.colour_shadow), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_shadow", 32'(bus.colour_shadow), 1);

        $display("[TB] CYCLE dwell=4, then stop when a pulse is due");
        applyStimulus(1'b1, MODE_CYCLE, 8'd4, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        waitTo(t0 + 1);
        applyStimulus(1'b0, MODE_CYCLE, 8'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("cyc_busy", 32'(bus.busy), 1);
        waitTo(t0 + 3);
        checkOutput("cyc_btn_T3", 32'(bus.button), 0);
        waitTo(t0 + 4);
        checkOutput("cyc_btn_T4", 32'(bus.button), 1);
        waitTo(t0 + 5);
        checkOutput("cyc_btn_T5", 32'(bus.button), 0);
        checkOutput("cyc_shadow_T5", 32'(bus.colour_shadow), 2);
        waitTo(t0 + 8);
        checkOutput("cyc_btn_T8", 32'(bus.button), 1);
        waitTo(t0 + 12);
        checkOutput("cyc_btn_T12", 32'(bus.button), 1);
        waitTo(t0 + 13);
        checkOutput("cyc_shadow_T13", 32'(bus.colour_shadow), 4);
        waitTo(t0 + 15);
        applyStimulus(1'b0, MODE_CYCLE, 8'd4, 1'b1, 1'b0, 1'b0);
        waitTo(t0 + 16);
        applyStimulus(1'b0, MODE_CYCLE, 8'd4, 1'b0, 1'b0, 1'b0);
        checkOutput("stop_btn", 32'(bus.button), 0);
        checkOutput("stop_busy", 32'(bus.busy), 0);
        checkOutput("stop_sel", 32'(bus.sel), 1);
        checkOutput("stop_done", 32'(bus.done), 0);

        $display("[TB] start and stop together in IDLE");
        applyStimulus(1'b1, MODE_CYCLE, 8'd2, 1'b1, 1'b0, 1'b0);
        t0 = cyc;
        waitTo(t0 + 1);
        applyStimulus(1'b0, MODE_CYCLE, 8'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("startstop_busy", 32'(bus.busy), 0);
        waitTo(t0 + 4);

        $display("[TB] CYCLE dwell=0 behaves as dwell=1");
        applyStimulus(1'b1, MODE_CYCLE, 8'd0, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        waitTo(t0 + 1);
        applyStimulus(1'b0, MODE_CYCLE, 8'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("dw0_btn_T1", 32'(bus.button), 1);
        waitTo(t0 + 4);
        checkOutput("dw0_btn_T4", 32'(bus.button), 1);
        waitTo(t0 + 7);
        applyStimulus(1'b0, MODE_CYCLE, 8'd0, 1'b1, 1'b0, 1'b0);
        waitTo(t0 + 8);
        applyStimulus(1'b0, MODE_CYCLE, 8'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("dw0_btn_after_stop", 32'(bus.button), 0);
        checkOutput("dw0_shadow", 32'(bus.colour_shadow), 5);

        $display("[TB] SWEEP dwell=2 with a second start ignored");
        applyStimulus(1'b1, MODE_SWEEP, 8'd2, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        waitTo(t0 + 1);
        applyStimulus(1'b0, MODE_SWEEP, 8'd2, 1'b0, 1'b0, 1'b0);
        waitTo(t0 + 5);
        applyStimulus(1'b1, MODE_BLINK, 8'd3, 1'b0, 1'b0, 1'b0);
        waitTo(t0 + 6);
        applyStimulus(1'b0, MODE_BLINK, 8'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("sweep_sel_T6", 32'(bus.sel), 1);
        waitTo(t0 + 12);
        checkOutput("sweep_btn_T12", 32'(bus.button), 1);
        checkOutput("sweep_busy_T12", 32'(bus.busy), 1);
        checkOutput("sweep_done_T12", 32'(bus.done), 0);
        waitTo(t0 + 13);
        checkOutput("sweep_done_T13", 32'(bus.done), 1);
        checkOutput("sweep_busy_T13", 32'(bus.busy), 0);
        checkOutput("sweep_shadow_T13", 32'(bus.colour_shadow), 5);
        waitTo(t0 + 14);
        checkOutput("sweep_done_T14", 32'(bus.done), 0);

        $display("[TB] BLINK dwell=3");
        applyStimulus(1'b1, MODE_BLINK, 8'd3, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        for (int j = 0; j < 9; j++) begin
            waitTo(t0 + j);
            if (j == 1) applyStimulus(1'b0, MODE_BLINK, 8'd3, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("blink_sel_T%0d", j), 32'(bus.sel), 32'(blinkSel[j]));
            checkOutput($sformatf("blink_btn_T%0d", j), 32'(bus.button), 0);
        end
        waitTo(t0 + 9);
        applyStimulus(1'b0, MODE_BLINK, 8'd3, 1'b1, 1'b0, 1'b0);
        waitTo(t0 + 10);
        applyStimulus(1'b0, MODE_BLINK, 8'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("blink_stop_sel", 32'(bus.sel), 1);

        $display("[TB] MANUAL pass-through");
        applyStimulus(1'b1, MODE_MANUAL, 8'd0, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        for (int j = 1; j <= 3; j++) begin
            waitTo(t0 + j);
            applyStimulus(1'b0, MODE_MANUAL, 8'd0, 1'b0, 1'b1, 1'b0);
        end
        waitTo(t0 + 4);
        applyStimulus(1'b0, MODE_MANUAL, 8'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("man_btn_T4", 32'(bus.button), 1);
        checkOutput("man_sel_T4", 32'(bus.sel), 0);
        waitTo(t0 + 5);
        checkOutput("man_btn_T5", 32'(bus.button), 0);
        checkOutput("man_sel_T5", 32'(bus.sel), 1);
        checkOutput("man_shadow_T5", 32'(bus.colour_shadow), 2);
        waitTo(t0 + 6);
        applyStimulus(1'b0, MODE_MANUAL, 8'd0, 1'b1, 1'b0, 1'b1);
        waitTo(t0 + 7);
        applyStimulus(1'b0, MODE_MANUAL, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of CYCLE");
        applyStimulus(1'b1, MODE_CYCLE, 8'd2, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        waitTo(t0 + 1);
        applyStimulus(1'b0, MODE_CYCLE, 8'd2, 1'b0, 1'b0, 1'b0);
        waitTo(t0 + 3);
        rst = 1'b1;
        waitTo(t0 + 4);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(bus.busy), 0);
        checkOutput("midrst_shadow", 32'(bus.colour_shadow), 0);
        checkOutput("midrst_done", 32'(bus.done), 0);
        checkOutput("midrst_sel", 32'(bus.sel), 1);
        waitTo(t0 + 5);
        checkOutput("midrst_shadow_after", 32'(bus.colour_shadow), 1);
        waitTo(t0 + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_show_sequencer.md
Name: light_show_sequencer

Overview:
- Controller that drives the button and sel inputs of the lights selector datapath. The selector has a 3-bit colour counter cycling 1..6, a colour-to-24-bit RGB converter, and a white/RGB mux.
- Offers four modes: manual pass-through, timed auto-cycle, white/colour blink, and a one-shot 6-colour sweep.
- Keeps a shadow copy of the selector's colour counter for status.
- Sits between the user/top-level controls and the selector instance.

Parameters:
DWELL_W, 8, width of the dwell (cycles-per-step) input
SWEEP_STEPS, 6, number of button pulses issued in SWEEP mode

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to enter mode_sel; honoured only in IDLE
mode_sel  input  2  00 MANUAL, 01 CYCLE, 10 BLINK, 11 SWEEP
stop  input  1  return to IDLE from any state
dwell  input  DWELL_W  cycles per step; sampled on accepted start; 0 treated as 1
man_button  input  1  manual button, forwarded in MANUAL
man_sel  input  1  manual sel, forwarded in MANUAL
button  output  1  to selector; 1 advances colour on that clock edge
sel  output  1  to selector; 1 = RGB colour, 0 = white
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on SWEEP completion
colour_shadow  output  3  mirror of the selector colour register

Behaviour:
- Single clock domain. Synchronous, active-high reset.
- All outputs are registered.
- Reset values: state=IDLE, button=0, sel=1, busy=0, done=0, colour_shadow=0, dwell_q=0, dwell_cnt=0, step_cnt=0.
- States: IDLE, MANUAL, CYCLE, BLINK, SWEEP.
- IDLE: button=0, sel=1.
  - start=1 and stop=0: latch dwell_q=max(dwell,1), load dwell_cnt=dwell_q-1, clear step_cnt, go to the state selected by mode_sel.
  - busy=1 from the next cycle.
- MANUAL: button<=man_button, sel<=man_sel every cycle, with 1-cycle latency. Exits only via stop.
- CYCLE: sel=1. dwell_cnt decrements each cycle. When dwell_cnt==0:
  - button=1 for exactly one cycle;
  - dwell_cnt reloads to dwell_q-1.
  - First pulse appears dwell_q cycles after the start cycle; pulse period is dwell_q.
  - dwell_q=1 gives button held high continuously.
- BLINK: button=0. sel starts at 1 and toggles every dwell_q cycles.
- SWEEP: pulses exactly as CYCLE; step_cnt counts pulses.
  - On the cycle after pulse number SWEEP_STEPS: state=IDLE, busy=0, done=1 for one cycle.
- stop:
  - In any non-IDLE state: IDLE on the next cycle, button=0, sel=1, done stays 0.
  - stop has priority over a pulse due in the same cycle and over start.
- start while busy is ignored; there is no restart or mode change.
- start and stop in the same cycle in IDLE: remain IDLE.
- colour_shadow tracks the selector's sampling of button on the same edge:
  - 0 goes to 1 unconditionally on the first cycle out of reset;
  - otherwise, if button==1: 6 goes to 1, n goes to n+1;
  - otherwise it holds.
- rst asserted mid-operation: all registers return to reset values on that edge; no done pulse.
- dwell changes while running have no effect; only the value latched at start is used.

Optional Feature:
LIGHT_SHOW_HOLD_EN
- Defined: adds input port hold (1 bit).
  - While hold=1 in CYCLE, BLINK or SWEEP: dwell_cnt and step_cnt are frozen, button=0, sel holds its value.
  - stop and rst are still honoured. hold has no effect in IDLE or MANUAL.
  - On release, counting resumes from the frozen value.
- Undefined: no hold port; behaviour is identical to hold tied to 0.

Decomposition:
- Package light_show_pkg holds:
  - mode encodings: MODE_MANUAL=2'b00, MODE_CYCLE=2'b01, MODE_BLINK=2'b10, MODE_SWEEP=2'b11;
  - state enum typedef;
  - colour constants COLOUR_MIN=3'd1, COLOUR_MAX=3'd6.
- Sub-module dwell_timer(clk, rst, load, load_val, run, tick) for the reload down-counter; tick is high when the count is 0 and run=1.
- FSM, colour_shadow and output registers live in the top.

Test Plan:
- Reset: rst=1 for 3 cycles -> button=0, sel=1, busy=0, done=0, colour_shadow=0. One cycle after rst drops -> colour_shadow=1.
- CYCLE, dwell=4, start at cycle T -> single-cycle button pulses at T+4, T+8, T+12; colour_shadow goes 1->2->3->4; sel stays 1; busy=1.
- SWEEP, dwell=2, colour_shadow=5 -> 6 pulses, colour_shadow 6,1,2,3,4,5; done=1 for exactly one cycle at T+13; busy=0 from T+13; a second start during the sweep is ignored.
- BLINK, dwell=3 -> sel sequence 1,1,1,0,0,0,1,1,1; button stays 0; dwell=0 in CYCLE -> button high every cycle.
- stop asserted in the cycle a CYCLE pulse is due -> no pulse, IDLE next cycle, sel=1, done=0. start+stop together in IDLE -> stays IDLE.
- MANUAL: man_button=1 for 3 cycles, man_sel=0 -> button high for 3 cycles delayed by 1, sel=0 delayed by 1, colour_shadow +3 with wrap 6->1.
